computer_top: RTL and testbench

COMPUTER_TOP -- requirements
Module: computer_top

---
 rtl/computer_pkg.sv | 46 ++++
 rtl/vga_timing.sv | 56 +++++
 rtl/computer_top.sv | 99 +++++++++
 tb/tb_computer_top.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared VGA timing constants, derived totals and the registered pixel-output bundle
// for the computer_top display slice.
package computer_pkg;

    localparam int CNT_W   = 10;
    localparam int FRAME_W = 16;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    function automatic int span_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int sync_first(input int vis, input int fp);
        return vis + fp;
    endfunction

    function automatic int sync_last(input int vis, input int fp, input int sync);
        return vis + fp + sync - 1;
    endfunction

    localparam int H_TOTAL      = span_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL      = span_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int H_SYNC_START = sync_first(H_VIS, H_FP);
    localparam int H_SYNC_END   = sync_last(H_VIS, H_FP, H_SYNC);
    localparam int V_SYNC_START = sync_first(V_VIS, V_FP);
    localparam int V_SYNC_END   = sync_last(V_VIS, V_FP, V_SYNC);

    typedef struct packed {
        logic [7:0] color;
        logic       hsync;
        logic       vsync;
        logic       on;
    } pixel_out_t;

    // Blanked pixel with both syncs inactive; also the reset value.
    localparam pixel_out_t PIXEL_IDLE = '{color: 8'h00, hsync: 1'b1, vsync: 1'b1, on: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical pixel counters advanced on the pixel tick, plus combinational
// sync, visible-area and end-of-frame decode of the current position.
module vga_timing #(
    parameter int H_VIS  = computer_pkg::H_VIS,
    parameter int H_FP   = computer_pkg::H_FP,
    parameter int H_SYNC = computer_pkg::H_SYNC,
    parameter int H_BP   = computer_pkg::H_BP,
    parameter int V_VIS  = computer_pkg::V_VIS,
    parameter int V_FP   = computer_pkg::V_FP,
    parameter int V_SYNC = computer_pkg::V_SYNC,
    parameter int V_BP   = computer_pkg::V_BP
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    output logic [computer_pkg::CNT_W-1:0] hcnt,
    output logic [computer_pkg::CNT_W-1:0] vcnt,
    output logic                           frame_end,
    output logic                           hsync_n,
    output logic                           vsync_n,
    output logic                           visible
);
    import computer_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(span_total(H_VIS, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(span_total(V_VIS, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(sync_first(H_VIS, H_FP));
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(sync_last(H_VIS, H_FP, H_SYNC));
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(sync_first(V_VIS, V_FP));
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(sync_last(V_VIS, V_FP, V_SYNC));
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);

    // vcnt steps only on the tick where hcnt wraps, so both wrap together at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (tick) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    always_comb begin
        hsync_n   = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
        vsync_n   = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
        visible   = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
    end

endmodule

// File: rtl/computer_top.sv
// Display pipeline top: pixel-tick phase toggle, frame counter, XOR test-pattern colour
// and the registered VGA outputs driven from the pre-increment timing position.
module computer_top #(
    parameter int H_VIS  = computer_pkg::H_VIS,
    parameter int H_FP   = computer_pkg::H_FP,
    parameter int H_SYNC = computer_pkg::H_SYNC,
    parameter int H_BP   = computer_pkg::H_BP,
    parameter int V_VIS  = computer_pkg::V_VIS,
    parameter int V_FP   = computer_pkg::V_FP,
    parameter int V_SYNC = computer_pkg::V_SYNC,
    parameter int V_BP   = computer_pkg::V_BP
) (
    input  logic       ext_clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] color,
    output logic       HSync,
    output logic       VSync,
    output logic       on
);
    import computer_pkg::*;

    logic               phase;
    logic               tick;
    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic [FRAME_W-1:0] frame;
    logic               frame_end;
    logic               hsync_n;
    logic               vsync_n;
    logic               visible;
    pixel_out_t         pix_d;
    pixel_out_t         pix_q;
    logic               unused_bits;

    // Pixel clock enable: every second ext_clk edge while enabled, frozen otherwise.
    assign tick = enable & phase;

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (enable) begin
            phase <= ~phase;
        end
    end

    vga_timing #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk       (ext_clk),
        .rst       (reset),
        .tick      (tick),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .frame_end (frame_end),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .visible   (visible)
    );

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            frame <= '0;
        end else if (tick && frame_end) begin
            frame <= frame + 16'd1;
        end
    end

    always_comb begin
        pix_d       = PIXEL_IDLE;
        pix_d.hsync = hsync_n;
        pix_d.vsync = vsync_n;
        pix_d.on    = visible;
        pix_d.color = visible ? (hcnt[7:0] ^ vcnt[7:0] ^ frame[7:0]) : 8'h00;
    end

    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            pix_q <= PIXEL_IDLE;
        end else if (tick) begin
            pix_q <= pix_d;
        end
    end

    assign color = pix_q.color;
    assign HSync = pix_q.hsync;
    assign VSync = pix_q.vsync;
    assign on    = pix_q.on;

    assign unused_bits = ^{frame[FRAME_W-1:8], hcnt[CNT_W-1:8], vcnt[CNT_W-1:8]};

endmodule

// File: tb/tb_computer_top.sv
// Scoreboard bench for computer_top: a default-timing instance and a shrunken-timing
// instance run side by side against a behavioural model, plus targeted timing checks.
module tb_computer_top;
    import computer_pkg::*;

    logic       ext_clk;
    logic       reset;
    logic       enable;
    logic [7:0] color_b;
    logic       hs_b;
    logic       vs_b;
    logic       on_b;
    logic [7:0] color_s;
    logic       hs_s;
    logic       vs_s;
    logic       on_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    computer_top dut (
        .ext_clk (ext_clk),
        .reset   (reset),
        .enable  (enable),
        .color   (color_b),
        .HSync   (hs_b),
        .VSync   (vs_b),
        .on      (on_b)
    );

    computer_top #(
        .H_VIS (6), .H_FP (2), .H_SYNC (3), .H_BP (1),
        .V_VIS (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_small (
        .ext_clk (ext_clk),
        .reset   (reset),
        .enable  (enable),
        .color   (color_s),
        .HSync   (hs_s),
        .VSync   (vs_s),
        .on      (on_s)
    );

    typedef struct {
        int         phase;
        int         h;
        int         v;
        int         f;
        pixel_out_t out;
    } model_t;

    typedef struct {
        int hvis;
        int hfp;
        int hsw;
        int hbp;
        int vvis;
        int vfp;
        int vsw;
        int vbp;
    } geom_t;

    geom_t      gBig;
    geom_t      gSmall;
    model_t     mBig;
    model_t     mSmall;
    pixel_out_t sbBig[$];
    pixel_out_t sbSmall[$];
    int         hsFalls[$];
    int         hsRises[$];
    logic       hsPrev;
    int         vsLow;
    int         vsFirstFall;

    initial begin
        ext_clk = 1'b0;
        forever #5 ext_clk = ~ext_clk;
    end

    function automatic model_t modelReset();
        model_t m;
        m.phase = 0;
        m.h     = 0;
        m.v     = 0;
        m.f     = 0;
        m.out   = '{color: 8'h00, hsync: 1'b1, vsync: 1'b1, on: 1'b0};
        return m;
    endfunction

    function automatic model_t modelEdge(input model_t m, input geom_t g, input logic en);
        model_t n;
        int     ht;
        int     vt;
        n  = m;
        ht = g.hvis + g.hfp + g.hsw + g.hbp;
        vt = g.vvis + g.vfp + g.vsw + g.vbp;
        if (en) begin
            if (m.phase == 1) begin
                n.out.on    = (m.h < g.hvis) && (m.v < g.vvis);
                n.out.hsync = !((m.h >= g.hvis + g.hfp) && (m.h < g.hvis + g.hfp + g.hsw));
                n.out.vsync = !((m.v >= g.vvis + g.vfp) && (m.v < g.vvis + g.vfp + g.vsw));
                n.out.color = n.out.on ? 8'(m.h ^ m.v ^ m.f) : 8'h00;
                if (m.h == ht - 1) begin
                    n.h = 0;
                    if (m.v == vt - 1) begin
                        n.v = 0;
                        n.f = (m.f + 1) & 32'hFFFF;
                    end else begin
                        n.v = m.v + 1;
                    end
                end else begin
                    n.h = m.h + 1;
                end
            end
            n.phase = m.phase ^ 1;
        end
        return n;
    endfunction

    function automatic int getAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en);
        reset  = rst;
        enable = en;
        if (rst) begin
            #1;
            mBig   = modelReset();
            mSmall = modelReset();
        end
    endtask

    task automatic clearEvents();
        cyc         = 0;
        hsFalls     = {};
        hsRises     = {};
        hsPrev      = 1'b1;
        vsLow       = 0;
        vsFirstFall = -1;
    endtask

    task automatic stepClock();
        pixel_out_t e;
        @(posedge ext_clk);
        if (!reset) begin
            mBig   = modelEdge(mBig, gBig, enable);
            mSmall = modelEdge(mSmall, gSmall, enable);
        end
        sbBig.push_back(mBig.out);
        sbSmall.push_back(mSmall.out);
        @(negedge ext_clk);
        cyc++;
        e = sbBig.pop_front();
        checkOutput("big_pix", 32'({color_b, hs_b, vs_b, on_b}), 32'(e));
        e = sbSmall.pop_front();
        checkOutput("small_pix", 32'({color_s, hs_s, vs_s, on_s}), 32'(e));
        if (hsPrev && !hs_b) hsFalls.push_back(cyc);
        if (!hsPrev && hs_b) hsRises.push_back(cyc);
        hsPrev = hs_b;
        if (!vs_s) begin
            if (cyc <= 194) vsLow++;
            if (vsFirstFall < 0) vsFirstFall = cyc;
        end
    endtask

    task automatic runTo(input int target);
        while (cyc < target) stepClock();
    endtask

    initial begin
        gBig   = '{640, 16, 96, 48, 480, 10, 2, 33};
        gSmall = '{6, 2, 3, 1, 4, 1, 2, 1};
        mBig   = modelReset();
        mSmall = modelReset();
        clearEvents();
        reset  = 1'b0;
        enable = 1'b0;
        #2 reset = 1'b1;

        @(negedge ext_clk);
        checkOutput("rst_color", 32'(color_b), 32'h00);
        checkOutput("rst_hsync", 32'(hs_b), 32'd1);
        checkOutput("rst_vsync", 32'(vs_b), 32'd1);
        checkOutput("rst_on", 32'(on_b), 32'd0);

        applyStimulus(1'b1, 1'b1);
        repeat (3) stepClock();
        checkOutput("rst_hold_on", 32'(on_b), 32'd0);

        applyStimulus(1'b0, 1'b1);
        clearEvents();
        stepClock();
        checkOutput("pre_tick_on", 32'(on_b), 32'd0);
        stepClock();
        checkOutput("first_on", 32'(on_b), 32'd1);
        checkOutput("first_color", 32'(color_b), 32'h00);
        checkOutput("first_hsync", 32'(hs_b), 32'd1);
        checkOutput("first_vsync", 32'(vs_b), 32'd1);

        runTo(194);
        checkOutput("sm_frame1_color", 32'(color_s), 32'h01);
        checkOutput("sm_frame1_on", 32'(on_s), 32'd1);
        checkOutput("sm_vs_fall", 32'(vsFirstFall), 32'd122);
        checkOutput("sm_vs_width", 32'(vsLow), 32'd48);

        runTo(4812);
        checkOutput("pix53_color", 32'(color_b), 32'h06);
        checkOutput("pix53_on", 32'(on_b), 32'd1);
        checkOutput("hs_first_fall", 32'(getAt(hsFalls, 0)), 32'd1314);
        checkOutput("hs_width", 32'(getAt(hsRises, 0) - getAt(hsFalls, 0)), 32'd192);
        checkOutput("line_period", 32'(getAt(hsFalls, 1) - getAt(hsFalls, 0)), 32'd1600);

        applyStimulus(1'b0, 1'b0);
        runTo(4862);
        checkOutput("pause_color", 32'(color_b), 32'h06);
        checkOutput("pause_on", 32'(on_b), 32'd1);
        applyStimulus(1'b0, 1'b1);
        runTo(6300);
        checkOutput("hs_fall_shift", 32'(getAt(hsFalls, 3)), 32'd6164);

        applyStimulus(1'b1, 1'b1);
        checkOutput("async_rst_hsync", 32'(hs_b), 32'd1);
        checkOutput("async_rst_vsync", 32'(vs_b), 32'd1);
        checkOutput("async_rst_on", 32'(on_b), 32'd0);
        checkOutput("async_rst_color", 32'(color_b), 32'h00);
        repeat (3) stepClock();

        applyStimulus(1'b0, 1'b1);
        clearEvents();
        stepClock();
        checkOutput("restart_pre_on", 32'(on_b), 32'd0);
        stepClock();
        checkOutput("restart_on", 32'(on_b), 32'd1);
        checkOutput("restart_color", 32'(color_b), 32'h00);
        checkOutput("restart_sm_color", 32'(color_s), 32'h00);

        repeat (2000) begin
            if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, ~enable);
            stepClock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
